// File: rtl/vc_queue_pkg.sv
// Shared encodings and sizing helpers for the valid/ready queue family.
// VC_QUEUE_PIPE_EN selects the pipe flavour that lets a dequeue free a full slot for an enqueue in the same cycle.
package vc_queue_pkg;

    typedef enum logic [0:0] {
        QUEUE_TYPE_NORMAL = 1'b0,
        QUEUE_TYPE_PIPE   = 1'b1
    } queue_type_e;

`ifdef VC_QUEUE_PIPE_EN
    localparam queue_type_e QUEUE_TYPE = QUEUE_TYPE_PIPE;
`else
    localparam queue_type_e QUEUE_TYPE = QUEUE_TYPE_NORMAL;
`endif

    // Pointer width never collapses to zero, even for a degenerate depth.
    function automatic int ptr_width(input int num_entries);
        int w;
        w = $clog2(num_entries);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/vc_queue_ctrl.sv
// Queue control: head/tail pointers and occupancy count; handshakes are combinational on state (and deq_rdy when VC_QUEUE_PIPE_EN).
// Full blocks enq_rdy unless the pipe build lets a same-cycle dequeue free the slot; empty never forwards.
module vc_queue_ctrl
    import vc_queue_pkg::*;
#(
    parameter int p_num_entries = 4,
    parameter int p_ptr_w       = ptr_width(p_num_entries),
    parameter int p_cnt_w       = p_ptr_w + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enq_val,
    output logic               enq_rdy,
    output logic               deq_val,
    input  logic               deq_rdy,
    output logic               wen,
    output logic [p_ptr_w-1:0] waddr,
    output logic [p_ptr_w-1:0] raddr,
    output logic [p_cnt_w-1:0] num_free_entries
);

    localparam logic [p_cnt_w-1:0] DEPTH = p_cnt_w'(p_num_entries);

    logic [p_ptr_w-1:0] enq_ptr;
    logic [p_ptr_w-1:0] deq_ptr;
    logic [p_cnt_w-1:0] count;

    logic full;
    logic empty;
    logic enq_fire;
    logic deq_fire;

    generate
        if (!is_pow2(p_num_entries)) begin : g_bad_depth
            $error("vc_queue_ctrl: p_num_entries must be a power of two >= 2");
        end
    endgenerate

    assign full  = (count == DEPTH);
    assign empty = (count == '0);

`ifdef VC_QUEUE_PIPE_EN
    // deq_val is necessarily high when full, so deq_rdy alone decides whether a slot opens.
    assign enq_rdy = !reset && (!full || deq_rdy);
`else
    assign enq_rdy = !reset && !full;
`endif
    assign deq_val = !reset && !empty;

    assign enq_fire = enq_val && enq_rdy;
    assign deq_fire = deq_val && deq_rdy;

    assign wen              = enq_fire;
    assign waddr            = enq_ptr;
    assign raddr            = deq_ptr;
    assign num_free_entries = DEPTH - count;

    always_ff @(posedge clk) begin
        if (reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
            count   <= '0;
        end else begin
            if (enq_fire) begin
                enq_ptr <= enq_ptr + 1'b1;
            end
            if (deq_fire) begin
                deq_ptr <= deq_ptr + 1'b1;
            end
            if (enq_fire && !deq_fire) begin
                count <= count + 1'b1;
            end else if (deq_fire && !enq_fire) begin
                count <= count - 1'b1;
            end
        end
    end

    a_count_range: assert property (@(posedge clk) disable iff (reset) count <= DEPTH);
    a_no_enq_full: assert property (@(posedge clk) disable iff (reset) (full && !deq_fire) |-> !enq_fire);
    a_no_deq_empty: assert property (@(posedge clk) disable iff (reset) empty |-> !deq_fire);

endmodule

// File: rtl/vc_val_rdy_queue.sv
// Valid/ready FIFO: register-array storage behind vc_queue_ctrl; 1-cycle minimum enq-to-deq latency, 1 msg/cycle sustained.
// Backpressure via enq_rdy (low when full, unless VC_QUEUE_PIPE_EN and deq_rdy); deq_msg is a pure function of state.
module vc_val_rdy_queue
    import vc_queue_pkg::*;
#(
    parameter int p_nbits       = 32,
    parameter int p_num_entries = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             enq_val,
    output logic                             enq_rdy,
    input  logic [p_nbits-1:0]               enq_msg,
    output logic                             deq_val,
    input  logic                             deq_rdy,
    output logic [p_nbits-1:0]               deq_msg,
    output logic [$clog2(p_num_entries):0]   num_free_entries
);

    localparam int PTR_W = ptr_width(p_num_entries);
    localparam int CNT_W = $clog2(p_num_entries) + 1;

    logic               wen;
    logic [PTR_W-1:0]   waddr;
    logic [PTR_W-1:0]   raddr;
    logic [p_nbits-1:0] storage [p_num_entries];

    vc_queue_ctrl #(
        .p_num_entries (p_num_entries),
        .p_ptr_w       (PTR_W),
        .p_cnt_w       (CNT_W)
    ) u_ctrl (
        .clk              (clk),
        .reset            (reset),
        .enq_val          (enq_val),
        .enq_rdy          (enq_rdy),
        .deq_val          (deq_val),
        .deq_rdy          (deq_rdy),
        .wen              (wen),
        .waddr            (waddr),
        .raddr            (raddr),
        .num_free_entries (num_free_entries)
    );

    // Storage carries no reset: validity is tracked entirely by the control count.
    always_ff @(posedge clk) begin
        if (wen) begin
            storage[waddr] <= enq_msg;
        end
    end

    assign deq_msg = storage[raddr];

endmodule
